// File: rtl/fifo_read_unpacker.sv
// fifo_read_unpacker: pops wide words from a synchronous FIFO read port and
// replays each word as DataWidth/OutWidth narrow beats on a valid/ready
// stream, least-significant chunk first. The next word is popped in the
// same cycle the final beat of the current word is accepted, so a steady
// FIFO supply yields a gap-free beat stream.
module fifo_read_unpacker #(
  parameter int DataWidth = 32,
  parameter int OutWidth  = 8,
  parameter int CntWidth  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 fifoEmpty,
  input  logic [DataWidth-1:0] fifoRdData,
  output logic                 fifoRdEn,
  output logic                 outValid,
  output logic [OutWidth-1:0]  outData,
  output logic                 outLast,
  input  logic                 outReady,
  output logic [CntWidth-1:0]  wordCount
);

  localparam int Beats     = DataWidth / OutWidth;
  localparam int BeatWidth = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(Beats - 1);

  // A word that does not split into whole beats would silently lose bits.
  if ((DataWidth % OutWidth) != 0) begin : g_width_check
    $error("fifo_read_unpacker: DataWidth must be a multiple of OutWidth");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q,      state_d;
  logic [DataWidth-1:0]  shift_q,      shift_d;
  logic [OutWidth-1:0]   out_data_q,   out_data_d;
  logic                  out_last_q,   out_last_d;
  logic [BeatWidth-1:0]  beat_q,       beat_d;
  logic [CntWidth-1:0]   word_count_q, word_count_d;

  logic accept;
  logic last_acc;
  logic can_load;
  logic rd_en;

  // Handshake qualifiers and the pop strobe. The pop is held off while reset
  // is asserted so the FIFO pointer never moves during reset.
  always_comb begin
    accept   = (state_q == SEND) && outReady;
    last_acc = accept && out_last_q;
    can_load = enable && !fifoEmpty;
    rd_en    = !rst && can_load && ((state_q == IDLE) || last_acc);
  end

  // Next-state: load a fresh word, advance to the next chunk, or go idle
  // once the final beat leaves with nothing to refill from.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    beat_d       = beat_q;
    word_count_d = word_count_q;

    if (rd_en) begin
      shift_d      = fifoRdData;
      out_data_d   = fifoRdData[OutWidth-1:0];
      beat_d       = '0;
      out_last_d   = (Beats == 1);
      state_d      = SEND;
      word_count_d = word_count_q + CntWidth'(1);
    end else if (accept) begin
      if (!out_last_q) begin
        beat_d     = beat_q + BeatWidth'(1);
        shift_d    = shift_q >> OutWidth;
        out_data_d = shift_d[OutWidth-1:0];
        out_last_d = (beat_d == LastBeat);
      end else begin
        // Data and last flag keep their final values while idle.
        state_d = IDLE;
      end
    end
  end

  // State and datapath registers, cleared asynchronously so a partially
  // sent word is dropped the moment reset arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      beat_q       <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      beat_q       <= beat_d;
      word_count_q <= word_count_d;
    end
  end

  // Output mapping; valid is simply "a word is in flight".
  always_comb begin
    fifoRdEn  = rd_en;
    outValid  = (state_q == SEND);
    outData   = out_data_q;
    outLast   = out_last_q;
    wordCount = word_count_q;
  end

endmodule

// File: tb/tb_fifo_read_unpacker.sv
// Bench for fifo_read_unpacker: a queue-based FIFO feeds the DUT, and a
// beat-queue reference model predicts valid/data/last/pop/count each cycle.
module tb_fifo_read_unpacker;

  localparam int DW    = 32;
  localparam int OW    = 8;
  localparam int CW    = 4;
  localparam int BEATS = DW / OW;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          fifoEmpty;
  logic [DW-1:0] fifoRdData;
  logic          fifoRdEn;
  logic          outValid;
  logic [OW-1:0] outData;
  logic          outLast;
  logic          outReady;
  logic [CW-1:0] wordCount;

  fifo_read_unpacker #(
    .DataWidth(DW),
    .OutWidth (OW),
    .CntWidth (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fifoEmpty (fifoEmpty),
    .fifoRdData(fifoRdData),
    .fifoRdEn  (fifoRdEn),
    .outValid  (outValid),
    .outData   (outData),
    .outLast   (outLast),
    .outReady  (outReady),
    .wordCount (wordCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] fifo_q[$];   // FIFO contents, head = next word to read
  logic [OW:0]   exp_q[$];    // beats still owed: {last, data}
  int unsigned   mcnt = 0;    // words popped since reset (model)

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive_fifo();
    fifoEmpty  = (fifo_q.size() == 0);
    fifoRdData = fifoEmpty ? DW'($urandom) : fifo_q[0];
  endtask

  // One clock cycle: compare DUT against the model, then advance both.
  task automatic step();
    logic          pred_vld;
    logic          pred_rd;
    logic          acc;
    logic [OW:0]   h;
    logic [DW-1:0] w;
    #2;
    pred_vld = (exp_q.size() > 0);
    pred_rd  = !rst && enable && (fifo_q.size() > 0) &&
               ((exp_q.size() == 0) || (outReady && exp_q.size() == 1));
    chk("outValid",  32'(outValid),  32'(pred_vld));
    chk("fifoRdEn",  32'(fifoRdEn),  32'(pred_rd));
    chk("wordCount", 32'(wordCount), mcnt % (1 << CW));
    if (pred_vld) begin
      h = exp_q[0];
      chk("outData", 32'(outData), 32'(h[OW-1:0]));
      chk("outLast", 32'(outLast), 32'(h[OW]));
    end
    acc = pred_vld && outReady;
    @(posedge clk);
    #1;
    if (acc) void'(exp_q.pop_front());
    if (pred_rd) begin
      w = fifo_q.pop_front();
      for (int b = 0; b < BEATS; b++)
        exp_q.push_back({(b == BEATS - 1), w[b*OW +: OW]});
      mcnt++;
    end
    drive_fifo();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    drive_fifo();
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b1;
    outReady = 1'b1;
    push(32'hDDCCBBAA);

    // Reset state, with a word available and enable high: no pop allowed.
    #3;
    chk("rst_outValid",  32'(outValid),  32'd0);
    chk("rst_outLast",   32'(outLast),   32'd0);
    chk("rst_outData",   32'(outData),   32'd0);
    chk("rst_wordCount", 32'(wordCount), 32'd0);
    chk("rst_fifoRdEn",  32'(fifoRdEn),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single word: AA,BB,CC,DD then idle.
    steps(7);
    chk("single_count", 32'(wordCount), 32'd1);
    chk("single_idle",  32'(outValid),  32'd0);

    // Back-to-back words: 8 contiguous beats, pop on last-beat accept.
    push(32'h03020100);
    push(32'h07060504);
    steps(11);
    chk("b2b_count", 32'(wordCount), 32'd3);

    // Backpressure while beat 22 is presented.
    push(32'h44332211);
    steps(2);
    outReady = 1'b0;
    steps(3);
    chk("bp_hold_data", 32'(outData), 32'h22);
    outReady = 1'b1;
    steps(5);

    // Gating: empty with enable, then data without enable.
    steps(3);
    push(32'hA3A2A1A0);
    push(32'hB3B2B1B0);
    enable = 1'b0;
    steps(3);
    chk("gate_no_pop", 32'(outValid), 32'd0);
    // Drop enable after the first beat: word drains, second word stays put.
    enable = 1'b1;
    steps(2);
    enable = 1'b0;
    steps(6);
    chk("gate_fifo_left", 32'(fifo_q.size()), 32'd1);
    enable = 1'b1;
    steps(6);

    // Reset in the middle of a word.
    push(32'hDDCCBBAA);
    steps(3);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_outValid",  32'(outValid),  32'd0);
    chk("arst_outLast",   32'(outLast),   32'd0);
    chk("arst_wordCount", 32'(wordCount), 32'd0);
    exp_q.delete();
    fifo_q.delete();
    mcnt = 0;
    push(32'h12345678);
    #1;
    chk("arst_fifoRdEn", 32'(fifoRdEn), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    steps(2);
    chk("arst_first_beat", 32'(outData), 32'h56);
    steps(5);

    // Counter wrap: 17 more words after reset land at 1 modulo 16.
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    mcnt = 0;
    for (int i = 0; i < 17; i++) fifo_q.push_back(DW'($urandom));
    drive_fifo();
    @(posedge clk);
    #1;
    rst = 1'b0;
    steps(17 * BEATS + 3);
    chk("wrap_count", 32'(wordCount), 32'd1);

    // Randomized supply, enable and backpressure.
    for (int i = 0; i < 600; i++) begin
      if (($urandom % 3 == 0) && (fifo_q.size() < 8)) push(DW'($urandom));
      enable   = ($urandom % 4) != 0;
      outReady = ($urandom % 3) != 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
